// File: rtl/radio_pkg.sv
// Shared definitions for the FM audio path: sample format, default
// de-emphasis coefficients, filter FSM states and the fixed-point rescale.
package radio_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int QBITS      = 10;

    localparam logic signed [31:0] IIR_X_COEFF = 32'sd178;
    localparam logic signed [31:0] IIR_Y_COEFF = 32'sd666;

    typedef enum logic [1:0] {
        S_READ  = 2'd0,
        S_MUL   = 2'd1,
        S_SUM   = 2'd2,
        S_WRITE = 2'd3
    } iir_state_t;

    // Divide by 2^qbits rounding toward zero (bias negatives before the
    // arithmetic shift) so results match the C golden model bit for bit.
    function automatic logic signed [31:0] dequantize(
        input logic signed [63:0] p,
        input int                 qbits = QBITS
    );
        logic signed [63:0] biased;
        logic signed [63:0] shifted;
        biased  = p[63] ? (p + ((64'sd1 <<< qbits) - 64'sd1)) : p;
        shifted = biased >>> qbits;
        return shifted[31:0];
    endfunction

endpackage

// File: rtl/iir_deemph.sv
// First-order IIR de-emphasis filter between two FIFOs: one sample every
// four cycles through read / multiply / sum / write.
module iir_deemph #(
    parameter int                DATA_WIDTH = radio_pkg::DATA_WIDTH,
    parameter int                QBITS      = radio_pkg::QBITS,
    parameter logic signed [31:0] X0_COEFF  = radio_pkg::IIR_X_COEFF,
    parameter logic signed [31:0] X1_COEFF  = radio_pkg::IIR_X_COEFF,
    parameter logic signed [31:0] Y1_COEFF  = radio_pkg::IIR_Y_COEFF
) (
    input  logic                  clock,
    input  logic                  reset,
    output logic                  in_rd_en,
    input  logic                  in_empty,
    input  logic [DATA_WIDTH-1:0] in_dout,
    output logic                  out_wr_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_din
);
    import radio_pkg::*;

    localparam int PROD_W = 2 * DATA_WIDTH;

    localparam logic signed [PROD_W-1:0] X0_EXT = PROD_W'(X0_COEFF);
    localparam logic signed [PROD_W-1:0] X1_EXT = PROD_W'(X1_COEFF);
    localparam logic signed [PROD_W-1:0] Y1_EXT = PROD_W'(Y1_COEFF);

    iir_state_t state_reg, state_next;

    logic signed [DATA_WIDTH-1:0] x_reg, x_prev, y_prev, y_reg;
    logic signed [PROD_W-1:0]     p0_reg, p1_reg, p2_reg;
    logic signed [DATA_WIDTH-1:0] sum_next;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= S_READ;
        end else begin
            state_reg <= state_next;
        end
    end

    // Pop is gated by reset so nothing is taken from the FIFO while held in reset.
    always_comb begin
        state_next = state_reg;
        in_rd_en   = 1'b0;
        out_wr_en  = 1'b0;
        case (state_reg)
            S_READ: begin
                if (reset && !in_empty) begin
                    in_rd_en   = 1'b1;
                    state_next = S_MUL;
                end
            end
            S_MUL:   state_next = S_SUM;
            S_SUM:   state_next = S_WRITE;
            S_WRITE: begin
                if (!out_full) begin
                    out_wr_en  = 1'b1;
                    state_next = S_READ;
                end
            end
            default: state_next = S_READ;
        endcase
    end

    // Sum wraps to the sample width; the feedback term uses the wrapped value.
    assign sum_next = DATA_WIDTH'(dequantize(p0_reg, QBITS)
                                + dequantize(p1_reg, QBITS)
                                + dequantize(p2_reg, QBITS));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x_reg  <= '0;
            x_prev <= '0;
            y_prev <= '0;
            y_reg  <= '0;
            p0_reg <= '0;
            p1_reg <= '0;
            p2_reg <= '0;
        end else begin
            case (state_reg)
                S_READ: begin
                    if (!in_empty) begin
                        x_reg <= in_dout;
                    end
                end
                S_MUL: begin
                    p0_reg <= X0_EXT * PROD_W'(x_reg);
                    p1_reg <= X1_EXT * PROD_W'(x_prev);
                    p2_reg <= Y1_EXT * PROD_W'(y_prev);
                end
                S_SUM: begin
                    y_reg  <= sum_next;
                    x_prev <= x_reg;
                    y_prev <= sum_next;
                end
                default: ;
            endcase
        end
    end

    assign out_din = y_reg;

endmodule

// File: tb/tb_iir_deemph.sv
// Scoreboard bench for iir_deemph: a FIFO model feeds directed samples,
// expected outputs are queued at issue and matched by a monitor on each write.
module tb_iir_deemph;

    localparam int W = 32;

    typedef struct {
        logic signed [W-1:0] x;
        int                  gap;
    } in_item_t;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                in_empty = 1'b1;
    logic                out_full = 1'b0;
    logic [W-1:0]        in_dout = '0;
    logic                in_rd_en;
    logic                out_wr_en;
    logic [W-1:0]        out_din;

    in_item_t            in_q[$];
    logic signed [W-1:0] exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rd_cycle = 0;
    bit lat_skip = 1'b0;

    iir_deemph dut (
        .clock    (clock),
        .reset    (reset),
        .in_rd_en (in_rd_en),
        .in_empty (in_empty),
        .in_dout  (in_dout),
        .out_wr_en(out_wr_en),
        .out_full (out_full),
        .out_din  (out_din)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Show-ahead input FIFO model; each item may be preceded by empty cycles.
    initial begin
        int gap;
        bit loaded;
        bit rd;
        gap = 0;
        loaded = 1'b0;
        forever begin
            @(negedge clock);
            rd = in_rd_en;
            @(posedge clock);
            #1;
            if (rd && in_q.size() > 0) begin
                void'(in_q.pop_front());
                loaded = 1'b0;
            end
            if (in_q.size() > 0 && !loaded) begin
                gap = in_q[0].gap;
                loaded = 1'b1;
            end
            if (in_q.size() > 0 && gap == 0) begin
                in_empty = 1'b0;
                in_dout  = in_q[0].x;
            end else begin
                if (gap > 0) gap--;
                in_empty = 1'b1;
                in_dout  = $urandom();
            end
        end
    end

    // Monitor: every write is matched against the oldest expected sample.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                if (in_rd_en) rd_cycle = cyc;
                if (out_wr_en) begin
                    chk("rd_wr_exclusive", in_rd_en, 0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", out_wr_en, 0);
                    end else begin
                        chk("out_din", $signed(out_din), exp_q.pop_front());
                    end
                    if (!lat_skip) chk("latency", cyc - rd_cycle, 3);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic signed [W-1:0] x, input int gap,
                        input bit expect_out, input logic signed [W-1:0] y);
        in_q.push_back('{x, gap});
        if (expect_out) exp_q.push_back(y);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < 400) begin
            @(posedge clock);
            n++;
        end
        chk({name, "_pending"}, in_q.size() + exp_q.size(), 0);
        in_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clock);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
    endtask

    initial begin
        logic signed [W-1:0] step_gold[5];
        int n;
        step_gold[0] = 178;
        step_gold[1] = 471;
        step_gold[2] = 662;
        step_gold[3] = 786;
        step_gold[4] = 867;

        // Reset state, with a sample already waiting at the FIFO head.
        send(1024, 0, 1'b1, 178);
        repeat (3) begin
            @(negedge clock);
            chk("reset_in_rd_en", in_rd_en, 0);
            chk("reset_out_wr_en", out_wr_en, 0);
            chk("reset_out_din", $signed(out_din), 0);
        end
        @(posedge clock);
        #1 reset = 1'b1;

        // Positive step, gapless.
        for (int i = 1; i < 5; i++) send(1024, 0, 1'b1, step_gold[i]);
        wait_idle("step_pos");

        // Negative step: truncation toward zero mirrors the positive case.
        do_reset();
        send(-1024, 0, 1'b1, -178);
        send(-1024, 0, 1'b1, -471);
        send(-1024, 0, 1'b1, -662);
        wait_idle("step_neg");

        // Truncation boundary: DQ(-534) = 0, DQ(534) = 0.
        do_reset();
        send(-3, 0, 1'b1, 0);
        send(0, 0, 1'b1, 0);
        send(3, 0, 1'b1, 0);
        wait_idle("trunc");

        // Full-width products at the sample extremes.
        do_reset();
        send(32'sh7FFFFFFF, 0, 1'b1, 373293055);
        send(32'sh80000000, 0, 1'b1, 242786302);
        wait_idle("extremes");

        // Backpressure: output held full with the next sample already waiting.
        do_reset();
        #1 out_full = 1'b1;
        lat_skip = 1'b1;
        send(1024, 0, 1'b1, 178);
        send(1024, 0, 1'b1, 471);
        send(1024, 0, 1'b1, 662);
        repeat (6) @(negedge clock);
        repeat (20) begin
            @(negedge clock);
            chk("stall_out_wr_en", out_wr_en, 0);
            chk("stall_in_rd_en", in_rd_en, 0);
            chk("stall_out_din", $signed(out_din), 178);
        end
        @(posedge clock);
        #1 out_full = 1'b0;
        wait_idle("backpressure");
        lat_skip = 1'b0;

        // Random empty bubbles must not change the sample-indexed output.
        do_reset();
        for (int i = 0; i < 5; i++) send(1024, $urandom_range(1, 7), 1'b1, step_gold[i]);
        wait_idle("bubbles");

        // Reset while the second sample is in S_SUM: it is dropped, history cleared.
        do_reset();
        send(1024, 0, 1'b1, 178);
        wait_idle("mid_reset_first");
        send(1024, 0, 1'b0, 0);
        n = 0;
        @(negedge clock);
        while (!in_rd_en && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("mid_reset_rd_seen", in_rd_en, 1);
        @(posedge clock);
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("mid_reset_out_din", $signed(out_din), 0);
        repeat (6) @(posedge clock);
        send(1024, 0, 1'b1, 178);
        wait_idle("mid_reset_next");

        repeat (5) @(posedge clock);
        chk("leftover_expected", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
